// File: rtl/run_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_sequencer : preloads DataMem, runs the core start/halt protocol, streams a result window back
// Rev 1.0
// ---------------------------------------------------------------------------
module run_sequencer #(
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 65535,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  load_len,
  input  logic [7:0]  rd_base,
  input  logic [7:0]  rd_len,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_data,
  output logic        start,
  input  logic        halt,
  output logic        dm_sel,
  output logic [7:0]  dm_addr,
  output logic        dm_wr,
  output logic [7:0]  dm_wdata,
  output logic        dm_rd,
  input  logic [7:0]  dm_rdata,
  output logic        rb_valid,
  input  logic        rb_ready,
  output logic [7:0]  rb_data,
  output logic        done,
  output logic        timed_out,
  output logic [31:0] run_cycles
);

  localparam logic [7:0]  c_START_LAST = 8'(START_CYCLES - 1);
  localparam logic [7:0]  c_RD_LAST    = 8'(RD_LAT - 1);
  localparam logic [31:0] c_TIMEOUT    = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_READ  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    R_ISSUE   = 2'd0,
    R_WAIT    = 2'd1,
    R_PRESENT = 2'd2
  } rphase_t;

  state_t      r_state;
  rphase_t     r_rphase;
  logic [7:0]  r_load_len;
  logic [7:0]  r_rd_base;
  logic [7:0]  r_rd_len;
  logic [7:0]  r_ptr;
  logic [7:0]  r_cnt;
  logic [7:0]  r_rb_data;
  logic        r_timed_out;
  logic [31:0] r_run_cycles;
  logic [31:0] w_run_next;

  assign w_run_next = r_run_cycles + 32'd1;

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_rphase     <= R_ISSUE;
      r_load_len   <= 8'd0;
      r_rd_base    <= 8'd0;
      r_rd_len     <= 8'd0;
      r_ptr        <= 8'd0;
      r_cnt        <= 8'd0;
      r_rb_data    <= 8'd0;
      r_timed_out  <= 1'b0;
      r_run_cycles <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_load_len   <= load_len;
            r_rd_base    <= rd_base;
            r_rd_len     <= rd_len;
            r_timed_out  <= 1'b0;
            r_run_cycles <= 32'd0;
            r_ptr        <= 8'd0;
            r_cnt        <= 8'd0;
            r_state      <= (load_len == 8'd0) ? S_START : S_LOAD;
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            r_ptr <= r_ptr + 8'd1;
            if (r_ptr == r_load_len - 8'd1) begin
              r_cnt   <= 8'd0;
              r_state <= S_START;
            end
          end
        end
        S_START: begin
          if (r_cnt == c_START_LAST) begin
            r_state <= S_RUN;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RUN: begin
          // The cycle that sees halt or reaches the limit is itself counted.
          r_run_cycles <= w_run_next;
          if (halt || (w_run_next == c_TIMEOUT)) begin
            r_timed_out <= ~halt;
            r_ptr       <= 8'd0;
            r_rphase    <= R_ISSUE;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          if (r_rd_len == 8'd0) begin
            r_state <= S_DONE;
          end else begin
            case (r_rphase)
              R_ISSUE: begin
                r_cnt    <= 8'd0;
                r_rphase <= R_WAIT;
              end
              R_WAIT: begin
                if (r_cnt == c_RD_LAST) begin
                  r_rb_data <= dm_rdata;
                  r_rphase  <= R_PRESENT;
                end else begin
                  r_cnt <= r_cnt + 8'd1;
                end
              end
              R_PRESENT: begin
                if (rb_ready) begin
                  r_ptr    <= r_ptr + 8'd1;
                  r_rphase <= R_ISSUE;
                  if (r_ptr == r_rd_len - 8'd1) r_state <= S_DONE;
                end
              end
              default: r_rphase <= R_ISSUE;
            endcase
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign ld_ready   = (r_state == S_LOAD);
  assign start      = (r_state == S_START);
  assign dm_sel     = !((r_state == S_START) || (r_state == S_RUN));
  assign dm_wr      = ld_ready && ld_valid;
  assign dm_wdata   = ld_ready ? ld_data : 8'd0;
  assign dm_rd      = (r_state == S_READ) && (r_rphase == R_ISSUE) && (r_rd_len != 8'd0);
  assign dm_addr    = ld_ready ? r_ptr :
                      (r_state == S_READ) ? (r_rd_base + r_ptr) : 8'd0;
  assign rb_valid   = (r_state == S_READ) && (r_rphase == R_PRESENT);
  assign rb_data    = r_rb_data;
  assign done       = (r_state == S_DONE);
  assign timed_out  = r_timed_out;
  assign run_cycles = r_run_cycles;

endmodule
`default_nettype wire
